// File: rtl/lift_lcd_status_if.sv
// Signal bundle between the elevator controller and the LCD status stage.
// The controller side is the master; the display stage is the slave.
interface lift_lcd_status_if;
  logic [1:0] iSTATE;
  logic [3:0] iFLOOR;
  logic [3:0] iTARGET;
  logic       iUPDATE;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       oBUSY;

  modport master (
    output iSTATE, iFLOOR, iTARGET, iUPDATE,
    input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, oBUSY
  );

  modport slave (
    input  iSTATE, iFLOOR, iTARGET, iUPDATE,
    output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, oBUSY
  );
endinterface

// File: rtl/lift_lcd_status.sv
// HD44780 16x2 status display for the elevator controller (8-bit, write-only).
// Optional feature: define LIFT_LCD_AUTOREFRESH_EN to refresh on any input change.
module lift_lcd_status #(
  parameter int PWRUP_WAIT = 750000,
  parameter int EN_CYCLES  = 16,
  parameter int CMD_WAIT   = 2000,
  parameter int CLR_WAIT   = 82000
) (
  input logic              iCLK,
  input logic              iRST,
  lift_lcd_status_if.slave bus
);
  localparam int MAX_A = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int MAX_B = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
  localparam int CW    = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2} top_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

  top_t          top, nxt_top;
  phase_t        phase;
  logic [CW-1:0] cnt, wait_last;
  logic [3:0]    idx, nxt_idx;
  logic [1:0]    snap_state;
  logic [3:0]    snap_floor, snap_target;
  logic          pending;
  logic [7:0]    lcd_data;
  logic          lcd_rs, lcd_en, busy;
  logic          req, byte_done, seq_last, seq_end, start_refresh;
  logic [8:0]    nxt_byte;

  function automatic logic [7:0] digit(input logic [3:0] v);
    return (v > 4'd8) ? 8'h2D : 8'h30 + {4'h0, v};
  endfunction

  // Returns {rs, data} for byte position i of sequence state st.
  function automatic logic [8:0] byte_of(input top_t st, input logic [3:0] i,
                                         input logic [1:0] s, input logic [3:0] f,
                                         input logic [3:0] t);
    logic [127:0] txt;
    logic [8:0]   b;
    txt = '0;
    b   = '0;
    case (st)
      INIT: begin
        case (i)
          4'd0:    b = 9'h038;
          4'd1:    b = 9'h00C;
          4'd2:    b = 9'h001;
          default: b = 9'h006;
        endcase
      end
      ADDR1: b = 9'h080;
      ADDR2: b = 9'h0C0;
      LINE1: begin
        case (s)
          2'd0:    txt = {"PARADO",   {10{8'h20}}};
          2'd1:    txt = {"SUBINDO",  {9{8'h20}}};
          2'd2:    txt = {"DESCENDO", {8{8'h20}}};
          default: txt = {"INATIVO",  {9{8'h20}}};
        endcase
        b = {1'b1, txt[{4'd15 - i, 3'b000} +: 8]};
      end
      LINE2: begin
        txt = {"ANDAR ", digit(f), " ALVO ", digit(t), 16'h2020};
        b   = {1'b1, txt[{4'd15 - i, 3'b000} +: 8]};
      end
      default: b = '0;
    endcase
    return b;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    nxt_top  = top;
    nxt_idx  = idx + 4'd1;
    seq_last = 1'b0;
    case (top)
      INIT:  seq_last = (idx == 4'd3);
      ADDR1: begin nxt_top = LINE1; nxt_idx = '0; end
      LINE1: if (idx == 4'd15) begin nxt_top = ADDR2; nxt_idx = '0; end
      ADDR2: begin nxt_top = LINE2; nxt_idx = '0; end
      LINE2: seq_last = (idx == 4'd15);
      default: ;
    endcase
  end

`ifdef LIFT_LCD_AUTOREFRESH_EN
  assign req = bus.iUPDATE ||
               ({bus.iSTATE, bus.iFLOOR, bus.iTARGET} != {snap_state, snap_floor, snap_target});
`else
  assign req = bus.iUPDATE;
`endif

  // The clear command needs the long settle time; everything else uses the short one.
  assign wait_last = (top == INIT && idx == 4'd2) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
  assign byte_done = (top inside {INIT, ADDR1, LINE1, ADDR2, LINE2}) &&
                     phase == PH_WAIT && cnt == wait_last;
  assign seq_end   = byte_done && seq_last;
  assign start_refresh = (top == IDLE && req) ||
                         (seq_end && (top == INIT || pending || req));
  assign nxt_byte  = byte_of(nxt_top, nxt_idx, snap_state, snap_floor, snap_target);

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      top         <= PWRUP;
      phase       <= PH_SETUP;
      cnt         <= '0;
      idx         <= '0;
      snap_state  <= '0;
      snap_floor  <= '0;
      snap_target <= '0;
      pending     <= 1'b0;
      lcd_data    <= 8'h00;
      lcd_rs      <= 1'b0;
      lcd_en      <= 1'b0;
      busy        <= 1'b1;
    end else if (start_refresh) begin
      top         <= ADDR1;
      idx         <= '0;
      phase       <= PH_SETUP;
      cnt         <= '0;
      snap_state  <= bus.iSTATE;
      snap_floor  <= bus.iFLOOR;
      snap_target <= bus.iTARGET;
      pending     <= 1'b0;
      lcd_data    <= 8'h80;
      lcd_rs      <= 1'b0;
      lcd_en      <= 1'b0;
      busy        <= 1'b1;
    end else begin
      if (req && top != IDLE && top != PWRUP) pending <= 1'b1;
      case (top)
        PWRUP: begin
          if (cnt == CW'(PWRUP_WAIT - 1)) begin
            top      <= INIT;
            idx      <= '0;
            phase    <= PH_SETUP;
            cnt      <= '0;
            lcd_data <= 8'h38;
            lcd_rs   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: ;
        default: begin
          case (phase)
            PH_SETUP: begin
              phase  <= PH_EN;
              lcd_en <= 1'b1;
              cnt    <= '0;
            end
            PH_EN: begin
              if (cnt == CW'(EN_CYCLES - 1)) begin
                phase  <= PH_WAIT;
                lcd_en <= 1'b0;
                cnt    <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              if (seq_end) begin
                top  <= IDLE;
                busy <= 1'b0;
                cnt  <= '0;
              end else if (byte_done) begin
                top                <= nxt_top;
                idx                <= nxt_idx;
                phase              <= PH_SETUP;
                cnt                <= '0;
                {lcd_rs, lcd_data} <= nxt_byte;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign bus.LCD_DATA = lcd_data;
  assign bus.LCD_RS   = lcd_rs;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_EN   = lcd_en;
  assign bus.oBUSY    = busy;
endmodule

// File: tb/tb_lift_lcd_status.sv
// Directed bench for lift_lcd_status with short timing parameters.
// Captures every LCD_EN rising edge and compares against hand-written text.
module tb_lift_lcd_status;
  localparam int PW      = 20;
  localparam int ENC     = 2;
  localparam int CMDW    = 4;
  localparam int CLRW    = 10;
  localparam int SLOT    = 1 + ENC + CMDW;
  localparam int REFRESH = 34 * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lift_lcd_status_if bus();

  lift_lcd_status #(
    .PWRUP_WAIT(PW), .EN_CYCLES(ENC), .CMD_WAIT(CMDW), .CLR_WAIT(CLRW)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
  } cap_t;

  cap_t cap[$];
  int   cyc    = 0;
  logic en_q   = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.LCD_EN === 1'b1 && en_q !== 1'b1)
      cap.push_back('{bus.LCD_RS, bus.LCD_DATA, cyc});
    en_q = bus.LCD_EN;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_update();
    bus.iUPDATE = 1'b1;
    step();
    bus.iUPDATE = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall, output bit ok);
    ok   = 1'b0;
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.oBUSY === 1'b0) begin
        ok   = 1'b1;
        fall = cyc;
        return;
      end
      step();
    end
  endtask

  function automatic logic [8:0] cap_byte(input int i);
    if (i < cap.size()) return {cap[i].rs, cap[i].data};
    return 'x;
  endfunction

  function automatic int cap_cyc(input int i);
    if (i < cap.size()) return cap[i].cyc;
    return -100000;
  endfunction

  function automatic string pad16(input string s);
    string r = s;
    while (r.len() < 16) r = {r, " "};
    return r;
  endfunction

  task automatic diff_refresh(input int base, input string l1, input string l2,
                              output int nbad, output int at,
                              output logic [8:0] got, output logic [8:0] want);
    string      p1;
    logic [8:0] e;
    p1   = pad16(l1);
    nbad = 0;
    at   = -1;
    got  = '0;
    want = '0;
    for (int i = 0; i < 34; i++) begin
      if (i == 0)       e = 9'h080;
      else if (i < 17)  e = {1'b1, p1[i-1]};
      else if (i == 17) e = 9'h0C0;
      else              e = {1'b1, l2[i-18]};
      if (cap_byte(base + i) !== e) begin
        if (nbad == 0) begin
          at   = i;
          got  = cap_byte(base + i);
          want = e;
        end
        nbad++;
      end
    end
  endtask

  task automatic test_reset();
    int  c0, rise;
    bit  seen;
    bus.iSTATE  = 2'd0;
    bus.iFLOOR  = 4'd3;
    bus.iTARGET = 4'd3;
    bus.iUPDATE = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.LCD_EN, bus.LCD_RS, bus.LCD_RW, bus.oBUSY, bus.LCD_DATA} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 8'h00})
      begin errors++; $display("FAIL reset_values: en/rs/rw/busy/data=%b got, want 0001_00000000",
                               {bus.LCD_EN, bus.LCD_RS, bus.LCD_RW, bus.oBUSY, bus.LCD_DATA}); end
    cap.delete();
    rst  = 1'b0;
    c0   = cyc;
    seen = 1'b0;
    rise = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (cyc - c0 == 10) begin
        checks++;
        if (bus.oBUSY !== 1'b1 || bus.LCD_EN !== 1'b0)
          begin errors++; $display("FAIL pwrup_quiet: busy=%b en=%b, want busy=1 en=0", bus.oBUSY, bus.LCD_EN); end
      end
      if (bus.LCD_EN === 1'b1) begin seen = 1'b1; rise = cyc; end
    end
    checks++;
    if (!seen || rise - c0 != PW + 1)
      begin errors++; $display("FAIL pwrup_delay: first EN at +%0d, want +%0d", rise - c0, PW + 1); end
  endtask

  task automatic test_init();
    int fall, nbad, at;
    bit ok;
    logic [8:0] g, w;
    logic [7:0] cmds [4];
    int gaps [4];
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    gaps = '{SLOT, SLOT, 1 + ENC + CLRW, SLOT};
    wait_idle(2000, fall, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout: busy never fell, want fall"); end
    checks++;
    if (cap.size() != 38) begin errors++; $display("FAIL init_count: %0d bytes, want 38", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_byte(i) !== {1'b0, cmds[i]})
        begin errors++; $display("FAIL init_cmd%0d: got %h, want %h", i, cap_byte(i), {1'b0, cmds[i]}); end
      checks++;
      if (cap_cyc(i + 1) - cap_cyc(i) != gaps[i])
        begin errors++; $display("FAIL init_gap%0d: got %0d, want %0d", i, cap_cyc(i + 1) - cap_cyc(i), gaps[i]); end
    end
    diff_refresh(4, "PARADO", "ANDAR 3 ALVO 3  ", nbad, at, g, w);
    checks++;
    if (nbad != 0)
      begin errors++; $display("FAIL init_text: %0d bad bytes, first #%0d got %h want %h", nbad, at, g, w); end
    checks++;
    if (fall - cap_cyc(37) != ENC + CMDW)
      begin errors++; $display("FAIL init_busy_fall: got +%0d after last EN, want +%0d", fall - cap_cyc(37), ENC + CMDW); end
  endtask

  task automatic test_update();
    int k, fall, nbad, at;
    bit ok;
    logic [8:0] g, w;
    cap.delete();
    checks++;
    if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL update_idle: busy=%b, want 0", bus.oBUSY); end
    k = cyc;
    bus.iSTATE  = 2'd1;
    bus.iFLOOR  = 4'd4;
    bus.iTARGET = 4'd7;
    pulse_update();
    checks++;
    if ({bus.oBUSY, bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA} !== {1'b1, 1'b0, 9'h080})
      begin errors++; $display("FAIL update_setup: busy/en/rs/data=%b got, want 1_0_0_10000000",
                               {bus.oBUSY, bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA}); end
    step();
    checks++;
    if (bus.LCD_EN !== 1'b1) begin errors++; $display("FAIL update_en_rise: en=%b at N+2, want 1", bus.LCD_EN); end
    step();
    step();
    checks++;
    if ({bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA} !== {1'b0, 9'h080})
      begin errors++; $display("FAIL update_hold: en/rs/data=%b in wait, want 0_0_10000000",
                               {bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA}); end
    wait_idle(1000, fall, ok);
    checks++;
    if (!ok || fall - k != 1 + REFRESH)
      begin errors++; $display("FAIL update_length: busy fell at N+%0d, want N+%0d", fall - k, 1 + REFRESH); end
    diff_refresh(0, "SUBINDO", "ANDAR 4 ALVO 7  ", nbad, at, g, w);
    checks++;
    if (nbad != 0)
      begin errors++; $display("FAIL update_text: %0d bad bytes, first #%0d got %h want %h", nbad, at, g, w); end
  endtask

  task automatic test_back_to_back();
    int k, fall, nbad, at;
    bit ok;
    logic [8:0] g, w;
    cap.delete();
    k = cyc;
    bus.iSTATE  = 2'd2;
    bus.iFLOOR  = 4'd5;
    bus.iTARGET = 4'd1;
    pulse_update();
    while (cyc - k < 120) begin
      bus.iUPDATE = (cyc - k == 20 || cyc - k == 50 || cyc - k == 100);
      if (cyc - k == 30) begin
        bus.iSTATE  = 2'd3;
        bus.iFLOOR  = 4'd0;
        bus.iTARGET = 4'd8;
      end
      step();
    end
    bus.iUPDATE = 1'b0;
    wait_idle(1000, fall, ok);
    checks++;
    if (!ok || fall - k != 1 + 2 * REFRESH)
      begin errors++; $display("FAIL b2b_length: busy fell at N+%0d, want N+%0d", fall - k, 1 + 2 * REFRESH); end
    diff_refresh(0, "DESCENDO", "ANDAR 5 ALVO 1  ", nbad, at, g, w);
    checks++;
    if (nbad != 0)
      begin errors++; $display("FAIL b2b_first: %0d bad bytes, first #%0d got %h want %h", nbad, at, g, w); end
    diff_refresh(34, "INATIVO", "ANDAR 0 ALVO 8  ", nbad, at, g, w);
    checks++;
    if (nbad != 0)
      begin errors++; $display("FAIL b2b_second: %0d bad bytes, first #%0d got %h want %h", nbad, at, g, w); end
    repeat (30) step();
    checks++;
    if (cap.size() != 68 || bus.oBUSY !== 1'b0)
      begin errors++; $display("FAIL b2b_coalesce: %0d bytes busy=%b, want 68 bytes busy=0", cap.size(), bus.oBUSY); end
  endtask

  task automatic test_same_cycle();
    int k, fall;
    bit ok;
    cap.delete();
    k = cyc;
    pulse_update();
    repeat (REFRESH - 1) step();
    checks++;
    if (bus.oBUSY !== 1'b1) begin errors++; $display("FAIL edge_last_wait: busy=%b, want 1", bus.oBUSY); end
    pulse_update();
    checks++;
    if ({bus.oBUSY, bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA} !== {1'b1, 1'b0, 9'h080})
      begin errors++; $display("FAIL edge_restart: busy/en/rs/data=%b got, want 1_0_0_10000000",
                               {bus.oBUSY, bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA}); end
    wait_idle(1000, fall, ok);
    checks++;
    if (!ok || fall - k != 1 + 2 * REFRESH || cap.size() != 68)
      begin errors++; $display("FAIL edge_length: fall N+%0d bytes %0d, want N+%0d bytes 68",
                               fall - k, cap.size(), 1 + 2 * REFRESH); end
  endtask

  task automatic test_dash();
    int fall, nbad, at;
    bit ok;
    logic [8:0] g, w;
    cap.delete();
    bus.iSTATE  = 2'd0;
    bus.iFLOOR  = 4'd12;
    bus.iTARGET = 4'd0;
    pulse_update();
    wait_idle(1000, fall, ok);
    diff_refresh(0, "PARADO", "ANDAR - ALVO 0  ", nbad, at, g, w);
    checks++;
    if (!ok || nbad != 0)
      begin errors++; $display("FAIL dash_floor: %0d bad bytes, first #%0d got %h want %h", nbad, at, g, w); end
    cap.delete();
    bus.iFLOOR  = 4'd8;
    bus.iTARGET = 4'd9;
    pulse_update();
    wait_idle(1000, fall, ok);
    diff_refresh(0, "PARADO", "ANDAR 8 ALVO -  ", nbad, at, g, w);
    checks++;
    if (!ok || nbad != 0)
      begin errors++; $display("FAIL dash_target: %0d bad bytes, first #%0d got %h want %h", nbad, at, g, w); end
  endtask

  task automatic test_reset_mid();
    int  c0, rise, fall;
    bit  seen, ok;
    logic [8:0] first;
    pulse_update();
    step();
    checks++;
    if (bus.LCD_EN !== 1'b1) begin errors++; $display("FAIL rstmid_pre: en=%b, want 1", bus.LCD_EN); end
    rst = 1'b1;
    step();
    checks++;
    if ({bus.LCD_EN, bus.oBUSY, bus.LCD_DATA} !== {1'b0, 1'b1, 8'h00})
      begin errors++; $display("FAIL rstmid_now: en/busy/data=%b got, want 0_1_00000000",
                               {bus.LCD_EN, bus.oBUSY, bus.LCD_DATA}); end
    rst   = 1'b0;
    c0    = cyc;
    seen  = 1'b0;
    rise  = -1;
    first = '0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (bus.LCD_EN === 1'b1) begin seen = 1'b1; rise = cyc; first = {bus.LCD_RS, bus.LCD_DATA}; end
    end
    checks++;
    if (!seen || rise - c0 != PW + 1 || first !== 9'h038)
      begin errors++; $display("FAIL rstmid_reinit: EN at +%0d byte %h, want +%0d byte 038", rise - c0, first, PW + 1); end
    wait_idle(2000, fall, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: busy never fell, want fall"); end
  endtask

  task automatic test_autorefresh();
    int k;
`ifdef LIFT_LCD_AUTOREFRESH_EN
    int fall, nbad, at;
    bit ok;
    logic [8:0] g, w;
    cap.delete();
    k = cyc;
    bus.iFLOOR = 4'd6;
    step();
    checks++;
    if ({bus.oBUSY, bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA} !== {1'b1, 1'b0, 9'h080})
      begin errors++; $display("FAIL auto_start: busy/en/rs/data=%b got, want 1_0_0_10000000",
                               {bus.oBUSY, bus.LCD_EN, bus.LCD_RS, bus.LCD_DATA}); end
    wait_idle(1000, fall, ok);
    checks++;
    if (!ok || fall - k != 1 + REFRESH)
      begin errors++; $display("FAIL auto_length: busy fell at N+%0d, want N+%0d", fall - k, 1 + REFRESH); end
    diff_refresh(0, "PARADO", "ANDAR 6 ALVO -  ", nbad, at, g, w);
    checks++;
    if (nbad != 0)
      begin errors++; $display("FAIL auto_text: %0d bad bytes, first #%0d got %h want %h", nbad, at, g, w); end
`else
    cap.delete();
    k = cyc;
    bus.iFLOOR = 4'd6;
    repeat (10) step();
    checks++;
    if (bus.oBUSY !== 1'b0 || cap.size() != 0)
      begin errors++; $display("FAIL no_auto: busy=%b bytes=%0d after %0d cycles, want busy=0 bytes=0",
                               bus.oBUSY, cap.size(), cyc - k); end
`endif
  endtask

  initial begin
    bus.iSTATE  = 2'd0;
    bus.iFLOOR  = 4'd0;
    bus.iTARGET = 4'd0;
    bus.iUPDATE = 1'b0;
    test_reset();
    test_init();
    test_update();
    test_back_to_back();
    test_same_cycle();
    test_dash();
    test_reset_mid();
    test_autorefresh();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lift_lcd_status.md
# lift_lcd_status

Downstream display stage of the elevator controller. Takes the controller's motion state, current floor and requested floor, and drives a 16x2 HD44780-compatible character LCD in 8-bit, write-only mode. Runs the power-up init, then rewrites both lines on every refresh request. It replaces the generic LCD test driver fed by the controller's state/refresh pulse.

## Interface
Parameters:
- PWRUP_WAIT, 750000: cycles idle after reset before the first init byte (15 ms at 50 MHz).
- EN_CYCLES, 16: cycles LCD_EN is held high per byte.
- CMD_WAIT, 2000: cycles after EN falls before the next byte (40 us).
- CLR_WAIT, 82000: replaces CMD_WAIT after the clear command 0x01 (1.64 ms).

Ports:
- iCLK  in  1  system clock (CLOCK_50).
- iRST  in  1  synchronous, active-high reset.
- iSTATE  in  2  motion state: 0 parado, 1 subindo, 2 descendo, 3 inativo.
- iFLOOR  in  4  current floor, valid range 0..8.
- iTARGET  in  4  requested floor, valid range 0..8.
- iUPDATE  in  1  one-cycle refresh request.
- LCD_DATA  out  8  data or command byte.
- LCD_RS  out  1  0 command, 1 character.
- LCD_RW  out  1  tied 0.
- LCD_EN  out  1  write strobe.
- oBUSY  out  1  high during init or refresh.

## Operation
- Top FSM states: PWRUP, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2.
- PWRUP: waits PWRUP_WAIT cycles, then moves to INIT.
- INIT: writes commands 0x38, 0x0C, 0x01, 0x06 in order, then performs one automatic refresh.
- Byte writer sub-FSM: SETUP (1 cycle; LCD_DATA and LCD_RS driven), EN (EN_CYCLES cycles; LCD_EN=1), WAIT (CMD_WAIT or CLR_WAIT cycles; LCD_EN=0).
  - LCD_DATA and LCD_RS hold their values from SETUP through the end of WAIT.
- Refresh sequence:
  - Snapshot iSTATE, iFLOOR and iTARGET on the refresh's first cycle.
  - Command 0x80, then 16 line-1 characters.
  - Command 0xC0, then 16 line-2 characters.
  - Total 34 bytes.
- Line 1 text by state, space-padded to 16 chars: "PARADO", "SUBINDO", "DESCENDO", "INATIVO".
- Line 2 text: "ANDAR f ALVO t  " (16 chars). f and t are ASCII '0'+value.
  - A floor or target value above 8 displays '-' (0x2D).
- Request handling:
  - iUPDATE in IDLE starts a refresh.
  - iUPDATE while busy (INIT or refresh) sets a single pending flag. Multiple requests coalesce into one.
  - When pending is set at the end of a refresh or init, a new refresh starts the next cycle and the flag clears.
- Inputs that change mid-refresh do not affect the refresh in progress (snapshot rule).

## Timing
- Reset values: LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, oBUSY=1, pending=0, FSM=PWRUP.
- iRST asserted mid-operation: LCD_EN is 0 on the next cycle, the FSM returns to PWRUP, and the full init repeats.
- Byte slot = 1 + EN_CYCLES + wait cycles. Refresh = 34 × (1 + EN_CYCLES + CMD_WAIT) cycles.
- iUPDATE at cycle N in IDLE:
  - oBUSY=1 at N+1.
  - SETUP of byte 0x80 at N+1; LCD_EN rises at N+2.
- oBUSY falls on the cycle after the last WAIT of the final character, unless pending is set. In that case oBUSY stays high.
- iUPDATE arriving on the same cycle a refresh finishes counts as pending: a back-to-back refresh follows, with no idle cycle.

## Configuration
- LIFT_LCD_AUTOREFRESH_EN defined: in IDLE, any difference between live iSTATE/iFLOOR/iTARGET and the last snapshot triggers a refresh exactly as iUPDATE does.
  - A difference arising while busy sets pending at the end of the current refresh.
- Not defined: refreshes occur only after init and on iUPDATE.

## Test plan
All scenarios use PWRUP_WAIT=20, EN_CYCLES=2, CMD_WAIT=4, CLR_WAIT=10.
- Reset, then run: after 20 idle cycles, LCD_EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0. The gap after 0x01 is 10 cycles; the other gaps are 4.
- Init with iSTATE=0, iFLOOR=3, iTARGET=3: the auto-refresh writes 0x80, "PARADO" plus 10 spaces, 0xC0, "ANDAR 3 ALVO 3  "; oBUSY then falls.
- In IDLE, set iSTATE=1, iFLOOR=4, iTARGET=7 and pulse iUPDATE at N: SETUP of 0x80 at N+1; line 1 "SUBINDO"; line 2 "ANDAR 4 ALVO 7  "; refresh lasts 34×7=238 cycles.
- Pulse iUPDATE three times during a refresh: exactly one additional refresh follows, back-to-back.
- Set iFLOOR=12 and iTARGET=0, then refresh: line 2 reads "ANDAR - ALVO 0  ".
- Assert iRST while LCD_EN=1: LCD_EN=0 and oBUSY=1 on the next cycle; init restarts after 20 cycles. With LIFT_LCD_AUTOREFRESH_EN defined, changing iFLOOR in IDLE with no iUPDATE starts a refresh on the next cycle.
